// File: rtl/dwt_pkg.sv
// Shared definitions for the DAUB-4 lifting DWT datapath:
// default Q16.16 format and the lifting/scaling coefficients.
package dwt_pkg;

    localparam int DWT_WIDTH = 32;
    localparam int DWT_FRAC  = 16;

    typedef logic signed [DWT_WIDTH-1:0] q_t;

    localparam q_t ALPHA  = 32'hFFFE4498;
    localparam q_t BETA   = 32'h00006EDA;
    localparam q_t GAMMA  = 32'hFFFFEEDA;
    localparam q_t LAMBDA = 32'h00010000;
    localparam q_t OMEGA  = 32'h0001EE8E;
    localparam q_t NABLA  = 32'h00008484;

endpackage

// File: rtl/lifting_mac_if.sv
// Sample/coefficient bundle of one lifting step: three samples and a
// coefficient in, the updated sample out.
interface lifting_mac_if
    import dwt_pkg::*;
#(
    parameter int WIDTH = DWT_WIDTH
);

    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] cons;
    logic [WIDTH-1:0] d;

    modport master (output in0, output in1, output in3, output cons, input d);
    modport slave  (input in0, input in1, input in3, input cons, output d);

endinterface

// File: rtl/q_mult.sv
// Signed fixed-point multiplier: p = (a*b) >>> FRAC, floor truncation, result
// wrapped to WIDTH bits. Optionally registered (latency 1).
module q_mult
    import dwt_pkg::*;
#(
    parameter int WIDTH   = DWT_WIDTH,
    parameter int FRAC    = DWT_FRAC,
    parameter int OUT_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] full_s;
    logic [WIDTH-1:0]   prod_s;

    // Sign-extending both operands makes the low 2*WIDTH bits of the plain
    // product equal the signed product; dropping the low FRAC bits floors.
    assign full_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_s = WIDTH'(full_s >> FRAC);

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [WIDTH-1:0] p_r;

            // Output register, cleared asynchronously.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    p_r <= {WIDTH{1'b0}};
                end else begin
                    p_r <= prod_s;
                end
            end

            assign p = p_r;
        end else begin : g_comb
            logic unused_s;
            assign unused_s = ^{clk, reset};
            assign p        = prod_s;
        end
    endgenerate

endmodule

// File: rtl/lifting_mac.sv
// One lifting step: d = in3 + cons*(in0 + in1) in signed Q(WIDTH-FRAC).FRAC,
// all arithmetic wrapping; d registered (latency 1) or combinational.
module lifting_mac
    import dwt_pkg::*;
#(
    parameter int WIDTH   = DWT_WIDTH,
    parameter int FRAC    = DWT_FRAC,
    parameter int OUT_REG = 1
) (
    input  logic          clk,
    input  logic          reset,
    lifting_mac_if.slave  bus
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] res_s;

    assign sum_s = bus.in0 + bus.in1;

    q_mult #(
        .WIDTH   (WIDTH),
        .FRAC    (FRAC),
        .OUT_REG (0)
    ) u_mult (
        .clk   (clk),
        .reset (reset),
        .a     (sum_s),
        .b     (bus.cons),
        .p     (prod_s)
    );

    assign res_s = bus.in3 + prod_s;

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [WIDTH-1:0] d_r;

            // Result register; reset discards any in-flight result.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    d_r <= {WIDTH{1'b0}};
                end else begin
                    d_r <= res_s;
                end
            end

            assign bus.d = d_r;
        end else begin : g_comb
            assign bus.d = res_s;
        end
    endgenerate

endmodule

// File: tb/tb_lifting_mac.sv
// Directed bench for lifting_mac (registered and combinational variants side
// by side) and the stand-alone registered q_mult.
module tb_lifting_mac;
    import dwt_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] qp;

    int passed = 0;
    int total  = 0;

    lifting_mac_if #(.WIDTH(32)) if_r ();
    lifting_mac_if #(.WIDTH(32)) if_c ();

    lifting_mac #(.WIDTH(32), .FRAC(16), .OUT_REG(1)) dut_r (
        .clk   (clk),
        .reset (reset),
        .bus   (if_r.slave)
    );

    lifting_mac #(.WIDTH(32), .FRAC(16), .OUT_REG(0)) dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (if_c.slave)
    );

    q_mult #(.WIDTH(32), .FRAC(16), .OUT_REG(1)) u_qm (
        .clk   (clk),
        .reset (reset),
        .a     (qa),
        .b     (qb),
        .p     (qp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    // Independent reference using 64-bit signed arithmetic.
    function automatic logic [31:0] model(input logic [31:0] a0, input logic [31:0] a1,
                                          input logic [31:0] a3, input logic [31:0] c);
        logic [31:0] s;
        longint      p;
        s = a0 + a1;
        p = longint'(signed'(s)) * longint'(signed'(c));
        p = p >>> 16;
        return a3 + p[31:0];
    endfunction

    task automatic drive(input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a3, input logic [31:0] c);
        if_r.in0 = a0; if_r.in1 = a1; if_r.in3 = a3; if_r.cons = c;
        if_c.in0 = a0; if_c.in1 = a1; if_c.in3 = a3; if_c.cons = c;
    endtask

    // Apply at negedge: comb variant checked same cycle, registered after the edge.
    task automatic step(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a3, input logic [31:0] c, input logic [31:0] exp);
        @(negedge clk);
        drive(a0, a1, a3, c);
        #1 chk({tag, "_comb"}, if_c.d, exp);
        @(posedge clk);
        #1 chk({tag, "_reg"}, if_r.d, exp);
    endtask

    task automatic qstep(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        @(negedge clk);
        qa = a;
        qb = b;
        @(posedge clk);
        #1 chk(tag, qp, exp);
    endtask

    initial begin
        logic [31:0] v0, v1, v3, vc;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        qa = 32'h0;
        qb = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(32'h1234_5678, 32'h0001_0000, 32'h0000_0001, 32'h0001_0000);
            qa = 32'h0001_0000;
            qb = 32'h0002_0000;
        end
        #1 chk("rst_reg_d", if_r.d, 32'h0);
        chk("rst_qmult_p", qp, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        step("s1_unity", 32'h0002_0000, 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000);
        step("s2_alpha", 32'h0001_0000, 32'h0, 32'h0, ALPHA, 32'hFFFE_4498);
        step("s2_alpha_sum", 32'h0001_0000, 32'h0001_0000, 32'h0, ALPHA, 32'hFFFC_8930);
        step("s3_floor", 32'h0000_0001, 32'h0, 32'h0, 32'hFFFF_8000, 32'hFFFF_FFFF);
        step("s4_wrap", 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 32'h0001_0000, 32'h8000_0000);
        step("beta_acc", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, BETA, 32'h0001_DDB4);

        for (int i = 0; i < 8; i++) begin
            v0 = $urandom;
            v1 = $urandom;
            v3 = $urandom;
            vc = $urandom;
            step($sformatf("s5_rand%0d", i), v0, v1, v3, vc, model(v0, v1, v3, vc));
        end

        #1 reset = 1'b1;
        #1 chk("s6_rst_mid_reg", if_r.d, 32'h0);
        chk("s6_rst_mid_qmult", qp, 32'h0);
        #1 reset = 1'b0;
        step("s6_after_rst", 32'h0002_0000, 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000);

        qstep("qm_omega", 32'h0001_0000, OMEGA, 32'h0001_EE8E);
        qstep("qm_neg_nabla", 32'hFFFF_0000, NABLA, 32'hFFFF_7B7C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
